// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control: ID decode, ID/EX, EX/MEM, MEM/WB bundles, load-use stall, EX branch flush.
// Define CTRL_JAL_EN to add JAL decode, EX redirect and the WB-stage Jump_o output.
module pipe_ctrl_unit #(
  parameter int OP_W    = 7,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic [RADDR_W-1:0] rs1_i,
  input  logic [RADDR_W-1:0] rs2_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic               Zero_i,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               MemtoReg_o,
  output logic               RegWrite_o,
`ifdef CTRL_JAL_EN
  output logic               Jump_o,
`endif
  output logic [RADDR_W-1:0] ExMemRd_o,
  output logic [RADDR_W-1:0] MemWbRd_o,
  output logic               Stall_o,
  output logic               Flush_o,
  output logic               PCSrc_o
);

  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_ST  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BR  = 7'b1100011;
`ifdef CTRL_JAL_EN
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;
`endif

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
`ifdef CTRL_JAL_EN
    logic               jump;
`endif
    logic [RADDR_W-1:0] rd;
  } mem_wb_t;

  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    mem_wb_t wb;
  } ex_mem_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               branch;
`ifdef CTRL_JAL_EN
    logic               jump;
`endif
    ex_mem_t            mem;
  } id_ex_t;

  id_ex_t  dec;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  logic is_r, is_i, is_ld, is_st, is_br;
  logic rs2_used, ex_hit, stall, flush;

  assign is_r  = (Op_i == OP_R);
  assign is_i  = (Op_i == OP_I);
  assign is_ld = (Op_i == OP_LD);
  assign is_st = (Op_i == OP_ST);
  assign is_br = (Op_i == OP_BR);

`ifdef CTRL_JAL_EN
  logic is_jal;
  assign is_jal = (Op_i == OP_JAL);
`endif

  // STORE/BRANCH keep rd=0 so they never look like a hazard or forward source
  always_comb begin
    dec = '0;
    if (start_i) begin
      unique case (1'b1)
        is_r: begin
          dec.mem.wb.reg_write = 1'b1;
          dec.alu_op           = 2'b10;
          dec.mem.wb.rd        = rd_i;
        end
        is_i: begin
          dec.mem.wb.reg_write = 1'b1;
          dec.alu_src          = 1'b1;
          dec.mem.wb.rd        = rd_i;
        end
        is_ld: begin
          dec.mem.wb.reg_write  = 1'b1;
          dec.alu_src           = 1'b1;
          dec.mem.mem_read      = 1'b1;
          dec.mem.wb.mem_to_reg = 1'b1;
          dec.mem.wb.rd         = rd_i;
        end
        is_st: begin
          dec.alu_src       = 1'b1;
          dec.mem.mem_write = 1'b1;
        end
        is_br: begin
          dec.branch = 1'b1;
          dec.alu_op = 2'b01;
        end
`ifdef CTRL_JAL_EN
        is_jal: begin
          dec.mem.wb.reg_write = 1'b1;
          dec.jump             = 1'b1;
          dec.mem.wb.jump      = 1'b1;
          dec.mem.wb.rd        = rd_i;
        end
`endif
        default: dec = '0;
      endcase
    end
  end

  assign rs2_used = is_r | is_st | is_br;

  assign ex_hit = id_ex.mem.mem_read
                & (id_ex.mem.wb.rd != '0)
                & ((id_ex.mem.wb.rd == rs1_i)
                 | ((id_ex.mem.wb.rd == rs2_i) & rs2_used));

`ifdef CTRL_JAL_EN
  assign flush = (id_ex.branch & Zero_i) | id_ex.jump;
`else
  assign flush = id_ex.branch & Zero_i;
`endif

  // a redirect makes the held ID instruction dead, so it must not stall
  assign stall = ex_hit & ~flush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      id_ex  <= (stall | flush) ? '0 : dec;
      ex_mem <= id_ex.mem;
      mem_wb <= ex_mem.wb;
    end
  end

  assign ALUOp_o    = id_ex.alu_op;
  assign ALUSrc_o   = id_ex.alu_src;
  assign MemRead_o  = ex_mem.mem_read;
  assign MemWrite_o = ex_mem.mem_write;
  assign ExMemRd_o  = ex_mem.wb.rd;
  assign MemtoReg_o = mem_wb.mem_to_reg;
  assign RegWrite_o = mem_wb.reg_write;
  assign MemWbRd_o  = mem_wb.rd;
`ifdef CTRL_JAL_EN
  assign Jump_o     = mem_wb.jump;
`endif
  assign Stall_o    = stall;
  assign Flush_o    = flush;
  assign PCSrc_o    = flush;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: per-feature tasks plus a stage scoreboard.
// Define CTRL_JAL_EN to also exercise the JAL path.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] NOP = 7'b0000000;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b1;
  logic [6:0] Op_i = '0;
  logic [4:0] rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic       Zero_i = 1'b0;
  logic [1:0] ALUOp_o;
  logic       ALUSrc_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o;
  logic [4:0] ExMemRd_o, MemWbRd_o;
  logic       Stall_o, Flush_o, PCSrc_o;
  logic       jmp;

  int errors = 0;
  int checks = 0;

  pipe_ctrl_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .Op_i(Op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .Zero_i(Zero_i),
    .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
    .RegWrite_o(RegWrite_o),
`ifdef CTRL_JAL_EN
    .Jump_o(jmp),
`endif
    .ExMemRd_o(ExMemRd_o), .MemWbRd_o(MemWbRd_o),
    .Stall_o(Stall_o), .Flush_o(Flush_o), .PCSrc_o(PCSrc_o)
  );

`ifndef CTRL_JAL_EN
  assign jmp = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src, branch, jump;
    logic       mem_read, mem_write, mem_to_reg, reg_write;
    logic [4:0] rd;
  } exp_t;

  function automatic exp_t model_dec(input logic st, input logic [6:0] op,
                                     input logic [4:0] rd);
    exp_t e = '0;
    if (!st) return e;
    case (op)
      R:  begin e.reg_write = 1; e.alu_op = 2'b10; e.rd = rd; end
      I:  begin e.reg_write = 1; e.alu_src = 1; e.rd = rd; end
      LD: begin
        e.reg_write = 1; e.alu_src = 1; e.mem_read = 1;
        e.mem_to_reg = 1; e.rd = rd;
      end
      ST: begin e.alu_src = 1; e.mem_write = 1; end
      BR: begin e.branch = 1; e.alu_op = 2'b01; end
`ifdef CTRL_JAL_EN
      JAL: begin e.reg_write = 1; e.jump = 1; e.rd = rd; end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB expectations
  exp_t pipe[$];
  exp_t bub = '0;
  exp_t ex_e, nx_e;
  logic st_e, fl_e;

  always @(negedge clk_i) begin : scoreboard
    if (!rst_i) begin
      pipe.delete();
      repeat (3) pipe.push_back(bub);
    end else begin
      ex_e = pipe[0];
      fl_e = (ex_e.branch && Zero_i) || ex_e.jump;
      st_e = !fl_e && ex_e.mem_read && ex_e.rd != 0 &&
             (ex_e.rd == rs1_i ||
              (ex_e.rd == rs2_i && (Op_i == R || Op_i == ST || Op_i == BR)));
      checks++;
      if ({Stall_o, Flush_o, PCSrc_o} !== {st_e, fl_e, fl_e}) begin
        errors++;
        $display("FAIL sb_hazard t=%0t got %b want %b", $time,
                 {Stall_o, Flush_o, PCSrc_o}, {st_e, fl_e, fl_e});
      end
      checks++;
      if ({ALUOp_o, ALUSrc_o} !== {pipe[0].alu_op, pipe[0].alu_src}) begin
        errors++;
        $display("FAIL sb_ex t=%0t got %b want %b", $time,
                 {ALUOp_o, ALUSrc_o}, {pipe[0].alu_op, pipe[0].alu_src});
      end
      checks++;
      if ({MemRead_o, MemWrite_o, ExMemRd_o} !==
          {pipe[1].mem_read, pipe[1].mem_write, pipe[1].rd}) begin
        errors++;
        $display("FAIL sb_mem t=%0t got %b want %b", $time,
                 {MemRead_o, MemWrite_o, ExMemRd_o},
                 {pipe[1].mem_read, pipe[1].mem_write, pipe[1].rd});
      end
      checks++;
      if ({MemtoReg_o, RegWrite_o, jmp, MemWbRd_o} !==
          {pipe[2].mem_to_reg, pipe[2].reg_write, pipe[2].jump,
           pipe[2].rd}) begin
        errors++;
        $display("FAIL sb_wb t=%0t got %b want %b", $time,
                 {MemtoReg_o, RegWrite_o, jmp, MemWbRd_o},
                 {pipe[2].mem_to_reg, pipe[2].reg_write, pipe[2].jump,
                  pipe[2].rd});
      end
      nx_e = (st_e || fl_e) ? bub : model_dec(start_i, Op_i, rd_i);
      pipe.push_front(nx_e);
      void'(pipe.pop_back());
    end
  end

  task automatic set_id(input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] d);
    Op_i = op; rs1_i = r1; rs2_i = r2; rd_i = d;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    set_id(R, 1, 2, 3);
    repeat (3) tick();
    checks++;
    if ({ALUOp_o, ALUSrc_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o,
         jmp, ExMemRd_o, MemWbRd_o, Stall_o, Flush_o, PCSrc_o} !== '0) begin
      errors++;
      $display("FAIL reset_zero got ALUOp=%b RegWrite=%b want 0",
               ALUOp_o, RegWrite_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (ALUOp_o !== 2'b10) begin
      errors++;
      $display("FAIL reset_r_ex got %b want 10", ALUOp_o);
    end
    set_id(NOP, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (RegWrite_o !== 1'b1 || MemWbRd_o !== 5'd3) begin
      errors++;
      $display("FAIL reset_r_wb got %b/%0d want 1/3", RegWrite_o, MemWbRd_o);
    end
  endtask

  task automatic test_load_store();
    set_id(LD, 1, 0, 5);
    tick();
    set_id(ST, 1, 2, 0);
    tick();
    checks++;
    if (MemRead_o !== 1'b1 || ExMemRd_o !== 5'd5) begin
      errors++;
      $display("FAIL ld_mem got %b/%0d want 1/5", MemRead_o, ExMemRd_o);
    end
    set_id(NOP, 0, 0, 0);
    tick();
    checks++;
    if (MemtoReg_o !== 1'b1 || MemWbRd_o !== 5'd5 || MemWrite_o !== 1'b1) begin
      errors++;
      $display("FAIL ld_wb_st_mem got %b/%0d/%b want 1/5/1",
               MemtoReg_o, MemWbRd_o, MemWrite_o);
    end
  endtask

  task automatic test_load_use();
    set_id(LD, 2, 0, 7);
    tick();
    set_id(R, 1, 7, 9);
    #1;
    checks++;
    if (Stall_o !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b want 1", Stall_o);
    end
    tick();
    checks++;
    if (ALUOp_o !== 2'b00 || ALUSrc_o !== 1'b0 || Stall_o !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble got %b/%b/%b want 00/0/0",
               ALUOp_o, ALUSrc_o, Stall_o);
    end
    tick();
    checks++;
    if (ALUOp_o !== 2'b10) begin
      errors++;
      $display("FAIL lu_r_ex got %b want 10", ALUOp_o);
    end
  endtask

  task automatic test_branch();
    set_id(BR, 1, 2, 0);
    tick();
    Zero_i = 1'b1;
    set_id(I, 1, 0, 4);
    #1;
    checks++;
    if ({PCSrc_o, Flush_o} !== 2'b11) begin
      errors++;
      $display("FAIL br_taken got %b want 11", {PCSrc_o, Flush_o});
    end
    tick();
    checks++;
    if (ALUSrc_o !== 1'b0 || Flush_o !== 1'b0) begin
      errors++;
      $display("FAIL br_bubble got %b/%b want 0/0", ALUSrc_o, Flush_o);
    end
    Zero_i = 1'b0;
    set_id(BR, 1, 2, 0);
    tick();
    set_id(I, 1, 0, 4);
    #1;
    checks++;
    if ({PCSrc_o, Flush_o} !== 2'b00) begin
      errors++;
      $display("FAIL br_not_taken got %b want 00", {PCSrc_o, Flush_o});
    end
    tick();
    checks++;
    if (ALUSrc_o !== 1'b1) begin
      errors++;
      $display("FAIL br_no_bubble got %b want 1", ALUSrc_o);
    end
  endtask

  task automatic test_flush_priority();
    set_id(LD, 1, 0, 3);
    tick();
    set_id(BR, 3, 0, 0);
    #1;
    checks++;
    if (Stall_o !== 1'b1) begin
      errors++;
      $display("FAIL fp_stall got %b want 1", Stall_o);
    end
    tick();
    tick();
    Zero_i = 1'b1;
    set_id(R, 3, 3, 6);
    #1;
    checks++;
    if (Flush_o !== 1'b1 || Stall_o !== 1'b0) begin
      errors++;
      $display("FAIL fp_flush_wins got %b/%b want 1/0", Flush_o, Stall_o);
    end
    tick();
    Zero_i = 1'b0;
    start_i = 1'b0;
    set_id(R, 1, 2, 6);
    tick();
    checks++;
    if (ALUOp_o !== 2'b00) begin
      errors++;
      $display("FAIL start_off_ex got %b want 00", ALUOp_o);
    end
    tick();
    tick();
    checks++;
    if (RegWrite_o !== 1'b0) begin
      errors++;
      $display("FAIL start_off_wb got %b want 0", RegWrite_o);
    end
    start_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    set_id(R, 1, 2, 8);
    tick();
    set_id(LD, 1, 2, 9);
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({ALUOp_o, ALUSrc_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o,
         jmp, ExMemRd_o, MemWbRd_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async got ALUOp=%b MemRead=%b want 0",
               ALUOp_o, MemRead_o);
    end
    tick();
    rst_i = 1'b1;
    set_id(NOP, 0, 0, 0);
    tick();
    checks++;
    if (RegWrite_o !== 1'b0 || MemRead_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop got %b/%b want 0/0", RegWrite_o, MemRead_o);
    end
  endtask

`ifdef CTRL_JAL_EN
  task automatic test_jal();
    Zero_i = 1'b0;
    set_id(JAL, 0, 0, 1);
    tick();
    checks++;
    if ({Flush_o, PCSrc_o} !== 2'b11) begin
      errors++;
      $display("FAIL jal_flush got %b want 11", {Flush_o, PCSrc_o});
    end
    set_id(NOP, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (RegWrite_o !== 1'b1 || jmp !== 1'b1 || MemWbRd_o !== 5'd1) begin
      errors++;
      $display("FAIL jal_wb got %b/%b/%0d want 1/1/1",
               RegWrite_o, jmp, MemWbRd_o);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [6:0] ops [8];
    ops = '{R, I, LD, ST, BR, JAL, 7'h7f, NOP};
    for (int n = 0; n < 60; n++) begin
      set_id(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      Zero_i = 1'($urandom_range(0, 1));
      start_i = ($urandom_range(0, 7) != 0);
      tick();
    end
    start_i = 1'b1;
    Zero_i = 1'b0;
    set_id(NOP, 0, 0, 0);
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_load_use();
    test_branch();
    test_flush_priority();
    test_reset_mid();
`ifdef CTRL_JAL_EN
    test_jal();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
